// File: rtl/pwm_frec_div_n.sv
// Multi-channel PWM generator driven by one shared period counter.
// New period/duty settings are staged and only take effect at a period boundary or while disabled.
module pwm_frec_div_n #(
    parameter int WIDTH       = 16,
    parameter int CHANNELS    = 4,
    parameter int DEFAULT_DIV = 3
) (
    input  logic                      cLocK,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      load,
    input  logic [WIDTH-1:0]          period,
    input  logic [CHANNELS*WIDTH-1:0] duty,
    output logic [CHANNELS-1:0]       NFrec,
    output logic                      tick,
    output logic                      load_ack,
    output logic                      pending,
    output logic [WIDTH-1:0]          cnt
);

    logic [WIDTH-1:0]          r_cnt;
    logic [WIDTH-1:0]          r_pActive;
    logic [CHANNELS*WIDTH-1:0] r_dutyActive;
    logic [WIDTH-1:0]          r_pPend;
    logic [CHANNELS*WIDTH-1:0] r_dutyPend;
    logic                      r_pending;
    logic [CHANNELS-1:0]       r_nfrec;
    logic                      r_tick;
    logic                      r_loadAck;

    logic [WIDTH-1:0]          w_pEff;
    logic [WIDTH-1:0]          w_last;
    logic                      w_wrap;
    logic                      w_apply;
    logic [WIDTH-1:0]          w_srcPer;
    logic [CHANNELS*WIDTH-1:0] w_srcDuty;
    logic [CHANNELS-1:0]       w_nfNext;

    // Periods of 0 or 1 are clamped to 2; >= keeps the wrap safe even if cnt were ever past the end.
    assign w_pEff    = (r_pActive < WIDTH'(2)) ? WIDTH'(2) : r_pActive;
    assign w_last    = w_pEff - WIDTH'(1);
    assign w_wrap    = en && (r_cnt >= w_last);
    assign w_apply   = (w_wrap || !en) && (load || r_pending);
    assign w_srcPer  = load ? period : r_pPend;
    assign w_srcDuty = load ? duty : r_dutyPend;

    always_comb begin
        w_nfNext = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_nfNext[i] = en && (r_cnt < r_dutyActive[i*WIDTH +: WIDTH]);
        end
    end

    always_ff @(posedge cLocK or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_pActive    <= WIDTH'(2 * DEFAULT_DIV);
            r_dutyActive <= {CHANNELS{WIDTH'(DEFAULT_DIV)}};
            r_pPend      <= '0;
            r_dutyPend   <= '0;
            r_pending    <= 1'b0;
            r_nfrec      <= '0;
            r_tick       <= 1'b0;
            r_loadAck    <= 1'b0;
        end else begin
            r_cnt     <= (!en || w_wrap) ? '0 : r_cnt + WIDTH'(1);
            r_nfrec   <= w_nfNext;
            r_tick    <= w_wrap;
            r_loadAck <= w_apply;
            // A load landing on an apply point bypasses the pending stage entirely.
            if (w_apply) begin
                r_pActive    <= w_srcPer;
                r_dutyActive <= w_srcDuty;
                r_pending    <= 1'b0;
            end else if (load) begin
                r_pPend    <= period;
                r_dutyPend <= duty;
                r_pending  <= 1'b1;
            end
        end
    end

    assign cnt      = r_cnt;
    assign NFrec    = r_nfrec;
    assign tick     = r_tick;
    assign load_ack = r_loadAck;
    assign pending  = r_pending;

endmodule

// File: doc/pwm_frec_div_n.md
PWM_FREC_DIV_N -- requirements
Module: pwm_frec_div_n

Interface
REQ-001 Parameter WIDTH, default 16, bit width of the period counter, period value and each duty value.
REQ-002 Parameter CHANNELS, default 4, number of PWM output channels sharing one period counter.
REQ-003 Parameter DEFAULT_DIV, default 3, reset-time half-period in clocks.
REQ-004 cLocK  in  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 en  in  1  run enable.
REQ-007 load  in  1  one-cycle strobe that captures period and duty into the pending registers.
REQ-008 period  in  WIDTH  requested period in clocks.
REQ-009 duty  in  CHANNELS*WIDTH  requested high time per channel; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-010 NFrec  out  CHANNELS  registered PWM outputs.
REQ-011 tick  out  1  one-cycle pulse per period wrap.
REQ-012 load_ack  out  1  one-cycle pulse when pending values become active.
REQ-013 pending  out  1  high while a captured load awaits application.
REQ-014 cnt  out  WIDTH  current counter value.

Function
REQ-015 Active period P_eff SHALL be max(P_active, 2); period values 0 and 1 SHALL both be treated as 2.
REQ-016 With en=1, cnt SHALL count 0..P_eff-1 and then wrap to 0; the wrap cycle is the cycle in which cnt==P_eff-1.
REQ-017 NFrec[i] SHALL register (en && cnt < duty_active[i]), one cycle behind cnt.
REQ-018 Consequences of REQ-017: duty 0 gives constant low; duty >= P_eff gives constant high.
REQ-019 tick SHALL go high for exactly one cycle, in the cycle after each wrap cycle.
REQ-020 On load=1 with no simultaneous wrap, period and duty SHALL be copied into the pending registers, and pending SHALL be 1 from the next cycle.
REQ-021 A load while pending=1 SHALL overwrite the pending values; only one load_ack SHALL result.
REQ-022 On a wrap cycle with pending=1, active SHALL take the pending values and pending SHALL clear, so the next period uses the new values.
REQ-023 On a wrap cycle with load=1, the values presented that cycle SHALL become active directly, bypassing and clearing pending.
REQ-024 load_ack SHALL pulse for one cycle in the cycle after the values are applied.
REQ-025 Active values SHALL never change except at a wrap cycle or while en=0, so no partial period with mixed settings occurs.
REQ-026 With en=0:
  - cnt SHALL be forced to 0 on the next clock.
  - NFrec SHALL be 0 and tick SHALL be 0.
  - A pending load, or a load asserted that cycle, SHALL be applied immediately with load_ack.
REQ-027 After en rises, the first period SHALL start at cnt=0 and have full length.
REQ-028 Duty comparison SHALL be unsigned over WIDTH bits; cnt SHALL never exceed P_eff-1, even when a new P_eff is smaller than the old cnt.

Reset
REQ-029 When rst_n=0, the block SHALL asynchronously reset to the following values:
  - cnt=0, NFrec=0, tick=0, load_ack=0, pending=0.
  - P_active=2*DEFAULT_DIV, with the width set by WIDTH.
  - duty_active[i]=DEFAULT_DIV for every channel.
REQ-030 Release of rst_n SHALL take effect synchronously, so the first count occurs on the first rising edge after deassertion while en=1.
REQ-031 Reset mid-period SHALL discard any pending load, and no load_ack SHALL follow the reset.

Verification
REQ-032 Default operation: reset with DEFAULT_DIV=3, then en=1 -> every channel repeats the pattern 111000 (period 6), with tick every 6 cycles.
REQ-033 Load mid-period: load period=10 and duty0=4 at cnt=2 -> pending=1, the current 6-cycle period completes, then load_ack pulses, and ch0 outputs 1111000000.
REQ-034 Boundary duty values: duty1=0 and duty2=12 with period=10 -> ch1 stays 0 and ch2 stays 1; period=1 -> a 2-cycle period with tick every 2 cycles.
REQ-035 Simultaneous and repeated loads:
  - load coincident with a wrap cycle -> the new values apply in the immediately following period, with no pending phase.
  - two loads within one period -> only the second set applies, with a single load_ack.
REQ-036 Enable and reset disruption:
  - en=0 mid-period -> cnt=0 and NFrec=0 on the next clock.
  - rst_n pulse while pending=1 -> all outputs reset, and the defaults (period 6) resume with no load_ack.
